dcache_ctrl: RTL

// - MEM-stage data-cache controller: responder for the EX/MEM pipeline register's memory request.
// - Consumes MemRead/MemWrite, ALU_Result (address) and read_data_2 (store data) from EX/MEM.
// - Produces the hit signal that freezes the pipeline registers during a miss.
// - Direct-mapped, one 16-bit word per line, write-through, no write-allocate.
// - Backed by a main memory through a req/ack handshake.

---
 rtl/dcache_pkg.sv | 21 ++
 rtl/dcache_array.sv | 46 ++++
 rtl/dcache_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped data cache.
package dcache_pkg;

  localparam int unsigned ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2,
    DONE    = 2'd3
  } state_e;

  function automatic int unsigned idx_width(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_width(input int unsigned lines);
    return ADDR_W - $clog2(lines);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Cache storage: LINES x {valid, tag, data}, combinational read, synchronous write.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned LINES  = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IDX_W  = idx_width(LINES),
  parameter int unsigned TAG_W  = tag_width(LINES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  // Only the valid bits are cleared; tag/data contents survive reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// MEM-stage data-cache controller: write-through, no write-allocate, req/ack backing memory.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned LINES  = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [15:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned IDX_W = idx_width(LINES);
  localparam int unsigned TAG_W = tag_width(LINES);

  state_e            state;
  logic [DATA_W-1:0] rd_buf;

  logic [IDX_W-1:0]  idx_c;
  logic [TAG_W-1:0]  tag_c;
  logic              line_valid_c;
  logic [TAG_W-1:0]  line_tag_c;
  logic [DATA_W-1:0] line_data_c;
  logic              lookup_hit_c;
  logic              is_write_c;
  logic              is_read_c;
  logic              arr_we_c;
  logic [DATA_W-1:0] arr_wdata_c;

  assign idx_c        = addr[IDX_W-1:0];
  assign tag_c        = addr[ADDR_W-1:IDX_W];
  assign lookup_hit_c = line_valid_c && (line_tag_c == tag_c);
  assign is_write_c   = mem_write;
  assign is_read_c    = mem_read && !mem_write;

  // Fill on a read-miss ack; update only already-present lines on a write ack.
  assign arr_we_c    = !rst && mem_ack &&
                       ((state == RD_MISS) || ((state == WR_THRU) && lookup_hit_c));
  assign arr_wdata_c = (state == RD_MISS) ? mem_rdata : write_data;

  dcache_array #(
    .LINES  (LINES),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (idx_c),
    .rd_valid (line_valid_c),
    .rd_tag   (line_tag_c),
    .rd_data  (line_data_c),
    .wr_en    (arr_we_c),
    .wr_idx   (idx_c),
    .wr_tag   (tag_c),
    .wr_data  (arr_wdata_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_buf    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_write_c) begin
            state     <= WR_THRU;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= write_data;
          end else if (is_read_c && !lookup_hit_c) begin
            state    <= RD_MISS;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= addr;
          end
        end
        RD_MISS: begin
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            rd_buf  <= mem_rdata;
          end
        end
        WR_THRU: begin
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // DONE holds hit high for one cycle so the stalled request is not reissued.
  always_comb begin
    hit       = 1'b0;
    read_data = '0;
    case (state)
      IDLE: begin
        if (!mem_read && !mem_write) begin
          hit = 1'b1;
        end else if (is_read_c && lookup_hit_c) begin
          hit       = 1'b1;
          read_data = line_data_c;
        end
      end
      DONE: begin
        hit = 1'b1;
        if (!mem_we) begin
          read_data = rd_buf;
        end
      end
      default: hit = 1'b0;
    endcase
  end

endmodule
